// File: rtl/accumulator_mc_pkg.sv
// Shared types and range-limit helpers for the multi-channel accumulate-and-dump engine.
package accumulator_mc_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_e;

   // Limits are returned as 128-bit two's-complement patterns; callers keep the low width bits.
   function automatic logic [127:0] acc_max(input int width, input bit is_signed);
      return is_signed ? ((128'd1 << (width - 1)) - 128'd1)
                       : ((128'd1 << width) - 128'd1);
   endfunction

   function automatic logic [127:0] acc_min(input int width, input bit is_signed);
      return is_signed ? ~((128'd1 << (width - 1)) - 128'd1) : 128'd0;
   endfunction

endpackage

// File: rtl/accumulator_lane.sv
// One accumulator lane: extend, add, wrap or clamp, and the sticky per-frame overflow bit.
module accumulator_lane
   import accumulator_mc_pkg::*;
#(
   parameter int BITWIDTH  = 32,
   parameter int ACC_WIDTH = 40,
   parameter bit SIGNED    = 1'b0,
   parameter bit SATURATE  = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 clr_i,
   input  logic                 beat_i,
   input  logic                 end_i,
   input  logic [BITWIDTH-1:0]  data_i,
   output logic [ACC_WIDTH-1:0] sum_o,
   output logic                 ovf_o
);

   localparam int EW = ACC_WIDTH + 1;
   localparam logic [127:0] MAX_L = acc_max(ACC_WIDTH, SIGNED);
   localparam logic [127:0] MIN_L = acc_min(ACC_WIDTH, SIGNED);
   localparam logic [ACC_WIDTH-1:0] MAX_V = MAX_L[ACC_WIDTH-1:0];
   localparam logic [ACC_WIDTH-1:0] MIN_V = MIN_L[ACC_WIDTH-1:0];

   logic [ACC_WIDTH-1:0] acc_q;
   logic                 ovf_q;
   logic [EW-1:0]        acc_x;
   logic [EW-1:0]        data_x;
   logic [EW-1:0]        raw;
   logic                 beat_ovf;

   // NOTE: combinational blocks use blocking assignments and give every output a value up
   // front, so later terms read the freshly computed ones and no latch is inferred.
   always_comb begin
      acc_x    = {1'b0, acc_q};
      data_x   = {{(EW - BITWIDTH){1'b0}}, data_i};
      beat_ovf = 1'b0;
      if (SIGNED) begin
         acc_x  = {acc_q[ACC_WIDTH-1], acc_q};
         data_x = {{(EW - BITWIDTH){data_i[BITWIDTH-1]}}, data_i};
      end
      raw = acc_x + data_x;
      // One guard bit holds any single-beat excursion, so its disagreement flags overflow.
      if (SIGNED) beat_ovf = raw[EW-1] != raw[EW-2];
      else        beat_ovf = raw[EW-1];
      sum_o = raw[ACC_WIDTH-1:0];
      if (SATURATE && beat_ovf) sum_o = (SIGNED && raw[EW-1]) ? MIN_V : MAX_V;
      ovf_o = ovf_q | beat_ovf;
   end

   // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else if (beat_i) begin
         acc_q <= end_i ? '0 : sum_o;
         ovf_q <= end_i ? 1'b0 : ovf_o;
      end
   end

endmodule

// File: rtl/accumulator_mc.sv
// Multi-channel accumulate-and-dump: sums CHANNELS lanes over a frame, then holds the result on valid/ready.
module accumulator_mc
   import accumulator_mc_pkg::*;
#(
   parameter int BITWIDTH  = 32,
   parameter int CHANNELS  = 4,
   parameter int ACC_WIDTH = 40,
   parameter int CNT_WIDTH = 16,
   parameter bit SIGNED    = 1'b0,
   parameter bit SATURATE  = 1'b0
) (
   input  logic                          iClk,
   input  logic                          iRst,
   input  logic                          iClr,
   input  logic [CNT_WIDTH-1:0]          iLen,
   input  logic                          iValid,
   output logic                          oReady,
   input  logic [CHANNELS*BITWIDTH-1:0]  iData,
   input  logic                          iLast,
   output logic                          oValid,
   input  logic                          iReady,
   output logic [CHANNELS*ACC_WIDTH-1:0] oData,
   output logic [CHANNELS-1:0]           oOvf
);

   state_e                        state_q, state_d;
   logic [CNT_WIDTH-1:0]          count_q, count_d;
   logic [CNT_WIDTH-1:0]          len_q, len_d;
   logic [CNT_WIDTH-1:0]          len_eff;
   logic [CHANNELS*ACC_WIDTH-1:0] data_q, data_d;
   logic [CHANNELS-1:0]           ovf_q, ovf_d;
   logic                          valid_q, valid_d;
   logic [CHANNELS*ACC_WIDTH-1:0] lane_sum;
   logic [CHANNELS-1:0]           lane_ovf;
   logic                          beat;
   logic                          frame_end;

   assign oReady    = (state_q == ACC) && !iRst && !iClr;
   assign beat      = iValid && oReady;
   // The first beat of a frame sees iLen directly, so a length of 1 ends on that same beat.
   assign len_eff   = (count_q == '0) ? iLen : len_q;
   assign frame_end = beat && (iLast || ((len_eff != '0) && (count_q == len_eff - CNT_WIDTH'(1))));

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      accumulator_lane #(
         .BITWIDTH (BITWIDTH),
         .ACC_WIDTH(ACC_WIDTH),
         .SIGNED   (SIGNED),
         .SATURATE (SATURATE)
      ) u_lane (
         .clk_i (iClk),
         .clr_i (iRst || iClr),
         .beat_i(beat),
         .end_i (frame_end),
         .data_i(iData[c*BITWIDTH +: BITWIDTH]),
         .sum_o (lane_sum[c*ACC_WIDTH +: ACC_WIDTH]),
         .ovf_o (lane_ovf[c])
      );
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      len_d   = len_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;
      if (iClr) begin
         count_d = '0;
         valid_d = 1'b0;
         state_d = ACC;
      end else begin
         case (state_q)
            ACC: begin
               if (beat) begin
                  if (count_q == '0) len_d = iLen;
                  if (frame_end) begin
                     data_d  = lane_sum;
                     ovf_d   = lane_ovf;
                     valid_d = 1'b1;
                     count_d = '0;
                     state_d = HOLD;
                  end else begin
                     count_d = count_q + CNT_WIDTH'(1);
                  end
               end
            end
            HOLD: begin
               if (iReady) begin
                  valid_d = 1'b0;
                  state_d = ACC;
               end
            end
            default: state_d = ACC;
         endcase
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= ACC;
         count_q <= '0;
         len_q   <= '0;
         data_q  <= '0;
         ovf_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         len_q   <= len_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign oData  = data_q;
   assign oOvf   = ovf_q;
   assign oValid = valid_q;

endmodule

// File: tb/tb_accumulator_mc.sv
// Randomized and directed bench for accumulator_mc: a 4x32/40 unsigned wrap instance plus
// two 2x8/8 signed instances (saturate and wrap) driven by the same handshake stimulus.
module tb_accumulator_mc;

   localparam int BW = 32, CH = 4, AW = 40, CW = 16;
   localparam int SBW = 8, SCH = 2, SAW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst, clr, valid, last, ready;
   logic [CW-1:0]       len;
   logic [CH*BW-1:0]    data;
   logic [SCH*SBW-1:0]  sdata;

   logic                rdy, vld, rdy_s, vld_s, rdy_w, vld_w;
   logic [CH*AW-1:0]    odata;
   logic [CH-1:0]       oovf;
   logic [SCH*SAW-1:0]  odata_s, odata_w;
   logic [SCH-1:0]      oovf_s, oovf_w;

   accumulator_mc #(.BITWIDTH(BW), .CHANNELS(CH), .ACC_WIDTH(AW), .CNT_WIDTH(CW),
                    .SIGNED(1'b0), .SATURATE(1'b0)) u_dut (
      .iClk(clk), .iRst(rst), .iClr(clr), .iLen(len), .iValid(valid), .oReady(rdy),
      .iData(data), .iLast(last), .oValid(vld), .iReady(ready), .oData(odata), .oOvf(oovf));

   accumulator_mc #(.BITWIDTH(SBW), .CHANNELS(SCH), .ACC_WIDTH(SAW), .CNT_WIDTH(CW),
                    .SIGNED(1'b1), .SATURATE(1'b1)) u_sat (
      .iClk(clk), .iRst(rst), .iClr(clr), .iLen(len), .iValid(valid), .oReady(rdy_s),
      .iData(sdata), .iLast(last), .oValid(vld_s), .iReady(ready), .oData(odata_s), .oOvf(oovf_s));

   accumulator_mc #(.BITWIDTH(SBW), .CHANNELS(SCH), .ACC_WIDTH(SAW), .CNT_WIDTH(CW),
                    .SIGNED(1'b1), .SATURATE(1'b0)) u_wrap (
      .iClk(clk), .iRst(rst), .iClr(clr), .iLen(len), .iValid(valid), .oReady(rdy_w),
      .iData(sdata), .iLast(last), .oValid(vld_w), .iReady(ready), .oData(odata_w), .oOvf(oovf_w));

   int n_vec = 0;
   int n_bad = 0;
   bit gaps  = 1'b0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer running sums per lane, with range rules applied per beat.
   longint m_acc[CH];
   bit     m_ovf[CH];
   int     m_sat[SCH], m_wrp[SCH];
   bit     m_sov[SCH], m_wov[SCH];

   logic [CH*AW-1:0]   exp_big;
   logic [CH-1:0]      exp_bovf;
   logic [SCH*SAW-1:0] exp_s, exp_w;
   logic [SCH-1:0]     exp_sov, exp_wov;

   task automatic model_clear();
      for (int c = 0; c < CH; c++) begin m_acc[c] = 0; m_ovf[c] = 1'b0; end
      for (int c = 0; c < SCH; c++) begin
         m_sat[c] = 0; m_wrp[c] = 0; m_sov[c] = 1'b0; m_wov[c] = 1'b0;
      end
   endtask

   task automatic model_beat(input logic [CH*BW-1:0] d, input logic [SCH*SBW-1:0] sd);
      int v;
      for (int c = 0; c < CH; c++) begin
         m_acc[c] += longint'(d[c*BW +: BW]);
         if (m_acc[c] >= (longint'(1) << AW)) begin
            m_ovf[c] = 1'b1;
            m_acc[c] -= (longint'(1) << AW);
         end
      end
      for (int c = 0; c < SCH; c++) begin
         v = int'($signed(sd[c*SBW +: SBW]));
         m_sat[c] += v;
         if (m_sat[c] > 127)       begin m_sov[c] = 1'b1; m_sat[c] = 127;  end
         else if (m_sat[c] < -128) begin m_sov[c] = 1'b1; m_sat[c] = -128; end
         m_wrp[c] += v;
         if (m_wrp[c] > 127)       begin m_wov[c] = 1'b1; m_wrp[c] -= 256; end
         else if (m_wrp[c] < -128) begin m_wov[c] = 1'b1; m_wrp[c] += 256; end
      end
   endtask

   task automatic model_end();
      for (int c = 0; c < CH; c++) begin
         exp_big[c*AW +: AW] = m_acc[c][AW-1:0];
         exp_bovf[c]         = m_ovf[c];
      end
      for (int c = 0; c < SCH; c++) begin
         exp_s[c*SAW +: SAW] = m_sat[c][SAW-1:0];
         exp_w[c*SAW +: SAW] = m_wrp[c][SAW-1:0];
         exp_sov[c]          = m_sov[c];
         exp_wov[c]          = m_wov[c];
      end
      model_clear();
   endtask

   // Called at a falling edge; returns at the falling edge just after the beat's rising edge.
   task automatic drive_beat(input logic [CH*BW-1:0] d, input logic [SCH*SBW-1:0] sd,
                             input bit lst, input bit fin);
      int t;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      t = 0;
      while (!rdy && t < 50) begin @(negedge clk); t++; end
      if (!rdy) check("ready_timeout", {255'd0, rdy}, 256'd1);
      data  = d;
      sdata = sd;
      last  = lst;
      valid = 1'b1;
      model_beat(d, sd);
      if (fin) model_end();
      @(negedge clk);
      valid = 1'b0;
      last  = 1'b0;
   endtask

   task automatic check_data(input string tag);
      check({tag, "_data"}, odata, exp_big);
      check({tag, "_ovf"},  oovf,  exp_bovf);
      check({tag, "_sat"},  {odata_s, oovf_s}, {exp_s, exp_sov});
      check({tag, "_wrap"}, {odata_w, oovf_w}, {exp_w, exp_wov});
   endtask

   task automatic expect_result();
      check("res_valid", {vld, vld_s, vld_w}, 3'b111);
      check("res_ready", {rdy, rdy_s, rdy_w}, 3'b000);
      check_data("res");
   endtask

   task automatic release_result(input int hold);
      repeat (hold) begin
         @(negedge clk);
         check("hold_valid", {vld, vld_s, vld_w}, 3'b111);
         check("hold_ready", {rdy, rdy_s, rdy_w}, 3'b000);
         check_data("hold");
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      check("ack_valid", {vld, vld_s, vld_w}, 3'b000);
      check("ack_ready", {rdy, rdy_s, rdy_w}, 3'b111);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  ul;
      rst = 1'b1; clr = 1'b0; valid = 1'b0; last = 1'b0; ready = 1'b0;
      len = '0; data = '0; sdata = '0;
      model_clear();
      repeat (2) @(negedge clk);
      check("rst_outputs", {vld, oovf, odata}, '0);
      check("rst_small", {vld_s, odata_s, oovf_s, vld_w, odata_w, oovf_w}, '0);
      check("rst_ready", {rdy, rdy_s, rdy_w}, 3'b000);
      rst = 1'b0;
      #1;
      check("post_rst_ready", {rdy, rdy_s, rdy_w}, 3'b111);

      // Four beats of {1,2,3,4}, iReady high immediately: one-cycle bubble.
      len = 16'd4;
      for (int b = 0; b < 4; b++)
         drive_beat({32'd4, 32'd3, 32'd2, 32'd1}, {8'd1, 8'd1}, 1'b0, b == 3);
      expect_result();
      check("t1_lanes", {oovf, odata}, {4'h0, 40'd16, 40'd12, 40'd8, 40'd4});
      release_result(0);

      // iLen=0, frame ended by iLast; result held five cycles.
      len = 16'd0;
      for (int b = 0; b < 3; b++)
         drive_beat(128'd5, {8'd0, 8'd5}, b == 2, b == 2);
      expect_result();
      check("t2_lane0", odata[AW-1:0], 40'd15);
      release_result(5);

      // Signed 8-bit: 100+100-50 saturates to 77 and wraps to -106.
      len = 16'd3;
      drive_beat({$urandom, $urandom, $urandom, $urandom}, {8'd0, 8'd100}, 1'b0, 1'b0);
      drive_beat({$urandom, $urandom, $urandom, $urandom}, {8'd0, 8'd100}, 1'b0, 1'b0);
      drive_beat({$urandom, $urandom, $urandom, $urandom}, {8'd0, 8'hCE}, 1'b0, 1'b1);
      expect_result();
      check("t3_sat",  {odata_s[7:0], oovf_s[0]}, {8'd77, 1'b1});
      check("t4_wrap", {odata_w[7:0], oovf_w[0]}, {8'h96, 1'b1});
      release_result(0);
      len = 16'd2;
      drive_beat(128'd1, {8'd0, 8'd1}, 1'b0, 1'b0);
      drive_beat(128'd1, {8'd0, 8'd2}, 1'b0, 1'b1);
      expect_result();
      check("t4_clean", {odata_w[7:0], oovf_w, oovf_s}, {8'd3, 2'b00, 2'b00});
      release_result(0);

      // Clear mid-frame after 2 of 4 beats; the beat in the clear cycle is refused.
      len = 16'd4;
      drive_beat({4{32'd1}}, {8'd1, 8'd1}, 1'b0, 1'b0);
      drive_beat({4{32'd1}}, {8'd1, 8'd1}, 1'b0, 1'b0);
      clr = 1'b1; valid = 1'b1; data = {4{32'd9}}; sdata = {8'd9, 8'd9};
      #1;
      check("t5_clr_ready", {rdy, rdy_s, rdy_w}, 3'b000);
      @(negedge clk);
      clr = 1'b0; valid = 1'b0;
      model_clear();
      #1;
      check("t5_after_clr", {vld, rdy, rdy_s, rdy_w}, 4'b0111);
      for (int b = 0; b < 4; b++)
         drive_beat({4{32'd1}}, {8'd1, 8'd1}, 1'b0, b == 3);
      expect_result();
      check("t5_fresh", odata, {4{40'd4}});
      release_result(0);

      // Clear while a result is held: it is discarded.
      len = 16'd2;
      drive_beat({4{32'd3}}, {8'd3, 8'd3}, 1'b0, 1'b0);
      drive_beat({4{32'd3}}, {8'd3, 8'd3}, 1'b0, 1'b1);
      expect_result();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("t5_hold_clr", {vld, vld_s, vld_w, rdy, rdy_s, rdy_w}, 6'b000111);
      repeat (3) begin
         @(negedge clk);
         check("t5_no_result", {vld, vld_s, vld_w}, 3'b000);
      end

      // Reset mid-frame together with iValid/iClr/iLast.
      len = 16'd4;
      drive_beat({$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 1'b0, 1'b0);
      rst = 1'b1; clr = 1'b1; valid = 1'b1; last = 1'b1;
      data = {4{32'hFFFF}}; sdata = 16'h7F7F;
      #1;
      check("t6_rst_ready", {rdy, rdy_s, rdy_w}, 3'b000);
      @(negedge clk);
      check("t6_rst_out", {vld, oovf, odata, vld_s, oovf_s, odata_s, vld_w, oovf_w, odata_w}, '0);
      rst = 1'b0; clr = 1'b0; valid = 1'b0; last = 1'b0;
      model_clear();
      len = 16'd1;
      drive_beat({4{32'd7}}, {8'd7, 8'd7}, 1'b0, 1'b1);
      expect_result();
      check("t6_single", {odata[AW-1:0], odata_s[7:0]}, {40'd7, 8'd7});
      release_result(0);

      // Long unsigned frame: 300 beats of all-ones wrap every 40-bit lane.
      len = 16'd0;
      for (int b = 0; b < 300; b++)
         drive_beat({4{32'hFFFF_FFFF}}, 16'($urandom), b == 299, b == 299);
      expect_result();
      check("long_ovf", oovf, 4'hF);
      release_result(1);

      // Random frames with input gaps and random result back-pressure.
      gaps = 1'b1;
      for (int f = 0; f < 40; f++) begin
         n  = $urandom_range(1, 6);
         ul = 1'($urandom_range(0, 1));
         len = ul ? CW'(n) : '0;
         for (int b = 0; b < n; b++)
            drive_beat({$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                       !ul && (b == n - 1), b == n - 1);
         expect_result();
         release_result($urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
